// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared RV32I constants, opcode values and instruction field slices.
package msrv32_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int IMM_MSB    = 31;
  localparam int IMM_LSB    = 7;
  // every RV32I opcode ends in 2'b11, so the set test also covers the quadrant bits
  function automatic logic is_legal(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL,
      OPCODE_JALR, OPCODE_BRANCH, OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP,
      OPCODE_MISC_MEM, OPCODE_SYSTEM};
  endfunction
endpackage

// File: rtl/msrv32_sync_fifo.sv
// msrv32_sync_fifo: generic synchronous FIFO with clear; a same-cycle read frees a slot for a write.
module msrv32_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd_valid = count != '0;
  assign rd = rd_valid & rd_ready & ~clr;
  assign wr_ready = (count != FULL) | rd | clr;
  assign wr = wr_valid & wr_ready & ~clr;
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst | clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= (wr & ~rd) ? count + 1'b1 : (rd & ~wr) ? count - 1'b1 : count;
    end
  end
endmodule

// File: rtl/msrv32_instr_fetch_buffer.sv
// msrv32_instr_fetch_buffer: elastic {pc, instr} buffer between imem and decode, NOP when empty.
// Optional ILLEGAL_OPCODE_CHECK_EN adds a registered illegal_instr_out flag per entry.
module msrv32_instr_fetch_buffer
  import msrv32_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = msrv32_pkg::NOP_INSTR,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [31:0]            instr_in,
  input  logic [31:0]            pc_in,
  input  logic                   in_valid_in,
  output logic                   in_ready_out,
  input  logic                   flush_in,
  input  logic                   out_ready_in,
  output logic                   out_valid_out,
  output logic [31:0]            instr_out,
  output logic [31:0]            pc_out,
  output logic [$clog2(DEPTH):0] count_out
`ifdef ILLEGAL_OPCODE_CHECK_EN
  ,
  output logic                   illegal_instr_out
`endif
);
`ifdef ILLEGAL_OPCODE_CHECK_EN
  localparam int W = 65;
`else
  localparam int W = 64;
`endif
  logic [W-1:0] wr_data, rd_data;
`ifdef ILLEGAL_OPCODE_CHECK_EN
  assign wr_data = {~is_legal(instr_in), pc_in, instr_in};
  assign illegal_instr_out = out_valid_out & rd_data[64];
`else
  assign wr_data = {pc_in, instr_in};
`endif
  msrv32_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .clr      (flush_in),
    .wr_valid (in_valid_in),
    .wr_ready (in_ready_out),
    .wr_data  (wr_data),
    .rd_valid (out_valid_out),
    .rd_ready (out_ready_in),
    .rd_data  (rd_data),
    .count    (count_out)
  );
  // storage is never reset, so the empty mux hides stale entries
  assign instr_out = out_valid_out ? rd_data[31:0] : NOP_INSTR;
  assign pc_out = out_valid_out ? rd_data[63:32] : RESET_PC;
endmodule

// File: tb/tb_msrv32_instr_fetch_buffer.sv
// tb_msrv32_instr_fetch_buffer: queue-model scoreboard for the fetch buffer with directed and random traffic.
module tb_msrv32_instr_fetch_buffer;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 0, rst_in = 1, in_valid_in = 0, flush_in = 0, out_ready_in = 0;
  logic [31:0] instr_in = 0, pc_in = 0;
  logic in_ready_out, out_valid_out;
  logic [31:0] instr_out, pc_out;
  logic [$clog2(DEPTH):0] count_out;
`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic illegal_instr_out;
`endif
  int checks = 0, errors = 0;
  ent_t q[$];
  ent_t pend;
  bit pend_v = 0;
  msrv32_instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst_in), .instr_in(instr_in), .pc_in(pc_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out), .flush_in(flush_in),
    .out_ready_in(out_ready_in), .out_valid_out(out_valid_out), .instr_out(instr_out),
    .pc_out(pc_out), .count_out(count_out)
`ifdef ILLEGAL_OPCODE_CHECK_EN
    , .illegal_instr_out(illegal_instr_out)
`endif
  );
  always #5 clk = ~clk;
  function automatic bit legal(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    return o inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    bit room;
    @(posedge clk);
    #1;
    rst_in = r; in_valid_in = v; pc_in = pc; instr_in = ins; out_ready_in = ordy; flush_in = fl;
    room = q.size() < DEPTH || (q.size() > 0 && ordy);
    pend = '{pc: pc, instr: ins};
    pend_v = !r && v && !fl && room;
  endtask
  always @(negedge clk) begin
    if (rst_in) begin
      q.delete();
      pend_v = 0;
    end else begin
      bit ev;
      ev = q.size() > 0;
      chk("out_valid", 64'(out_valid_out), 64'(ev));
      chk("count", 64'(count_out), 64'(q.size()));
      chk("instr", 64'(instr_out), 64'(ev ? q[0].instr : NOP));
      chk("pc", 64'(pc_out), 64'(ev ? q[0].pc : 32'h0));
      chk("in_ready", 64'(in_ready_out), 64'(q.size() < DEPTH || flush_in || (ev && out_ready_in)));
`ifdef ILLEGAL_OPCODE_CHECK_EN
      chk("illegal", 64'(illegal_instr_out), 64'(ev && !legal(q[0].instr)));
`endif
      if (flush_in) q.delete();
      else begin
        if (ev && out_ready_in) void'(q.pop_front());
        if (pend_v) q.push_back(pend);
      end
      pend_v = 0;
    end
  end
  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 32'h100, 32'h0050_0093, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 32'h104, 32'h0010_0113, 0, 0);
    drive(0, 1, 32'h108, 32'h0020_0193, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 32'h1F0, 32'h0000_0000, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 32'h300 + 4 * i, 32'h0000_0013 | (i << 20), 1, 0);
    drive(0, 1, 32'h10C, 32'h0030_0213, 0, 1);
    drive(0, 1, 32'h200, 32'h0000_0000, 0, 0);
    drive(0, 1, 32'h204, 32'h0000_0013, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 32'h208, 32'h0000_0013, 0, 0);
    drive(1, 1, 32'h20C, 32'h0000_0013, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 1) == 1) ins[6:0] = 7'h13;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom(), ins,
            $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
